memctrl_port_arbiter: RTL and testbench

//   Shares the single memctrl0 port between two requesters. Requester 0 is the

---
 rtl/memctrl_port_arbiter_if.sv | 34 +++
 rtl/memctrl_port_arbiter.sv | 115 +++++++++++
 tb/tb_memctrl_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memctrl_port_arbiter_if.sv
// Bundle of the two requester ports and the memctrl0 port seen by memctrl_port_arbiter.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface memctrl_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] a0_wadd, a1_wadd, a0_radd, a1_radd;
  logic [DATA_WIDTH-1:0] a0_idat, a1_idat, a0_odat, a1_odat;
  logic                  a0_wren, a1_wren, a0_rden, a1_rden;
  logic                  a0_wrdy, a1_wrdy, a0_rrdy, a1_rrdy;
  logic                  a0_oval, a1_oval;

  logic [ADDR_WIDTH-1:0] memctrl0_wadd, memctrl0_radd;
  logic [DATA_WIDTH-1:0] memctrl0_idat, memctrl0_odat;
  logic                  memctrl0_wren, memctrl0_rden, memctrl0_oval;

  modport slave (
    input  a0_wadd, a1_wadd, a0_radd, a1_radd, a0_idat, a1_idat,
    input  a0_wren, a1_wren, a0_rden, a1_rden,
    output a0_wrdy, a1_wrdy, a0_rrdy, a1_rrdy,
    output a0_odat, a1_odat, a0_oval, a1_oval,
    output memctrl0_wadd, memctrl0_radd, memctrl0_idat, memctrl0_wren, memctrl0_rden,
    input  memctrl0_odat, memctrl0_oval
  );

  modport master (
    output a0_wadd, a1_wadd, a0_radd, a1_radd, a0_idat, a1_idat,
    output a0_wren, a1_wren, a0_rden, a1_rden,
    input  a0_wrdy, a1_wrdy, a0_rrdy, a1_rrdy,
    input  a0_odat, a1_odat, a0_oval, a1_oval,
    input  memctrl0_wadd, memctrl0_radd, memctrl0_idat, memctrl0_wren, memctrl0_rden,
    output memctrl0_odat, memctrl0_oval
  );
endinterface

// File: rtl/memctrl_port_arbiter.sv
// Two-requester arbiter for the memctrl0 port: independent write/read grants with fixed
// priority to requester 0, a starvation override for requester 1, and a tag FIFO routing read returns.
module memctrl_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  memctrl_port_arbiter_if.slave        bus,
  output logic                         o_err_oval,
  output logic [$clog2(TAG_DEPTH):0]   o_outstanding
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]        wstarve, rstarve;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic [TAG_DEPTH-1:0] tag_mem;

  logic wstarved, rstarved, full, empty;
  logic w0_win, w1_win, r0_win, r1_win;
  logic push, pop, pop_id;

  assign wstarved = (wstarve == SW'(STARVE_LIMIT));
  assign rstarved = (rstarve == SW'(STARVE_LIMIT));
  assign full     = (count == (PW+1)'(TAG_DEPTH));
  assign empty    = (count == '0);

  // Grants are gated by rst so every output reads 0 while reset is held.
  assign w1_win = rst & bus.a1_wren & (wstarved | ~bus.a0_wren);
  assign w0_win = rst & bus.a0_wren & ~w1_win;
  assign r1_win = rst & ~full & bus.a1_rden & (rstarved | ~bus.a0_rden);
  assign r0_win = rst & ~full & bus.a0_rden & ~r1_win;

  assign bus.a0_wrdy = w0_win;
  assign bus.a1_wrdy = w1_win;
  assign bus.a0_rrdy = r0_win;
  assign bus.a1_rrdy = r1_win;

  assign push          = r0_win | r1_win;
  assign pop           = bus.memctrl0_oval & ~empty;
  assign pop_id        = tag_mem[rd_ptr];
  assign o_outstanding = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.memctrl0_wadd <= '0;
      bus.memctrl0_idat <= '0;
      bus.memctrl0_wren <= 1'b0;
      bus.memctrl0_radd <= '0;
      bus.memctrl0_rden <= 1'b0;
      bus.a0_odat       <= '0;
      bus.a1_odat       <= '0;
      bus.a0_oval       <= 1'b0;
      bus.a1_oval       <= 1'b0;
      wstarve           <= '0;
      rstarve           <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      tag_mem           <= '0;
      o_err_oval        <= 1'b0;
    end else begin
      bus.memctrl0_wren <= w0_win | w1_win;
      if (w0_win) begin
        bus.memctrl0_wadd <= bus.a0_wadd;
        bus.memctrl0_idat <= bus.a0_idat;
      end else if (w1_win) begin
        bus.memctrl0_wadd <= bus.a1_wadd;
        bus.memctrl0_idat <= bus.a1_idat;
      end

      bus.memctrl0_rden <= push;
      if (r0_win)
        bus.memctrl0_radd <= bus.a0_radd;
      else if (r1_win)
        bus.memctrl0_radd <= bus.a1_radd;

      if (bus.a1_wren & ~w1_win)
        wstarve <= wstarved ? wstarve : wstarve + 1'b1;
      else
        wstarve <= '0;

      if (bus.a1_rden & ~r1_win)
        rstarve <= rstarved ? rstarve : rstarve + 1'b1;
      else
        rstarve <= '0;

      if (push) begin
        tag_mem[wr_ptr] <= r1_win;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)
        count <= count + 1'b1;
      else if (pop & ~push)
        count <= count - 1'b1;

      bus.a0_oval <= pop & ~pop_id;
      bus.a1_oval <= pop & pop_id;
      if (pop & ~pop_id)
        bus.a0_odat <= bus.memctrl0_odat;
      if (pop & pop_id)
        bus.a1_odat <= bus.memctrl0_odat;

      // A return with nothing outstanding is dropped and flagged until reset.
      if (bus.memctrl0_oval & empty)
        o_err_oval <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memctrl_port_arbiter.sv
// Randomized and directed bench for memctrl_port_arbiter against a queue-based reference model.
module tb_memctrl_port_arbiter;
  localparam int TD = 4;
  localparam int SL = 8;

  logic       clk;
  logic       rst;
  logic       o_err_oval;
  logic [2:0] o_outstanding;

  memctrl_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  memctrl_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_DEPTH(TD), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .o_err_oval(o_err_oval), .o_outstanding(o_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int          wst, rsv, cyc;
  bit          q_id[$];
  int          q_cyc[$];
  bit          m_err;
  bit          e_wren, e_rden, e_oval0, e_oval1;
  logic [31:0] e_wadd, e_idat, e_radd, e_odat0, e_odat1;
  bit          g_w0, g_w1, g_r0, g_r1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wst = 0; rsv = 0; m_err = 0;
    q_id.delete(); q_cyc.delete();
    e_wren = 0; e_rden = 0; e_oval0 = 0; e_oval1 = 0;
    e_wadd = '0; e_idat = '0; e_radd = '0; e_odat0 = '0; e_odat1 = '0;
  endtask

  task automatic clear_inputs();
    bus.a0_wren = 0; bus.a1_wren = 0; bus.a0_rden = 0; bus.a1_rden = 0;
    bus.a0_wadd = '0; bus.a1_wadd = '0; bus.a0_radd = '0; bus.a1_radd = '0;
    bus.a0_idat = '0; bus.a1_idat = '0;
    bus.memctrl0_oval = 0; bus.memctrl0_odat = '0;
  endtask

  // One clock: compare grants mid-cycle, advance the model, compare registered outputs after the edge.
  task automatic step();
    bit full, pid;
    @(negedge clk);
    full = (q_id.size() == TD);
    g_w1 = bus.a1_wren && (wst == SL || !bus.a0_wren);
    g_w0 = bus.a0_wren && !g_w1;
    g_r1 = !full && bus.a1_rden && (rsv == SL || !bus.a0_rden);
    g_r0 = !full && bus.a0_rden && !g_r1;
    chk("a0_wrdy", bus.a0_wrdy, g_w0);
    chk("a1_wrdy", bus.a1_wrdy, g_w1);
    chk("a0_rrdy", bus.a0_rrdy, g_r0);
    chk("a1_rrdy", bus.a1_rrdy, g_r1);

    wst = (bus.a1_wren && !g_w1) ? ((wst < SL) ? wst + 1 : SL) : 0;
    rsv = (bus.a1_rden && !g_r1) ? ((rsv < SL) ? rsv + 1 : SL) : 0;

    e_wren = g_w0 || g_w1;
    if (g_w0) begin e_wadd = bus.a0_wadd; e_idat = bus.a0_idat; end
    else if (g_w1) begin e_wadd = bus.a1_wadd; e_idat = bus.a1_idat; end
    e_rden = g_r0 || g_r1;
    if (g_r0) e_radd = bus.a0_radd;
    else if (g_r1) e_radd = bus.a1_radd;

    e_oval0 = 0; e_oval1 = 0;
    if (bus.memctrl0_oval) begin
      if (q_id.size() == 0) m_err = 1;
      else begin
        pid = q_id.pop_front();
        void'(q_cyc.pop_front());
        if (pid) begin e_oval1 = 1; e_odat1 = bus.memctrl0_odat; end
        else     begin e_oval0 = 1; e_odat0 = bus.memctrl0_odat; end
      end
    end
    if (g_r0 || g_r1) begin q_id.push_back(g_r1); q_cyc.push_back(cyc); end

    @(posedge clk);
    #1;
    cyc++;
    chk("mem_wren", bus.memctrl0_wren, e_wren);
    chk("mem_wadd", bus.memctrl0_wadd, e_wadd);
    chk("mem_idat", bus.memctrl0_idat, e_idat);
    chk("mem_rden", bus.memctrl0_rden, e_rden);
    chk("mem_radd", bus.memctrl0_radd, e_radd);
    chk("a0_oval", bus.a0_oval, e_oval0);
    chk("a1_oval", bus.a1_oval, e_oval1);
    chk("a0_odat", bus.a0_odat, e_odat0);
    chk("a1_odat", bus.a1_odat, e_odat1);
    chk("err_oval", o_err_oval, m_err);
    chk("outstanding", o_outstanding, q_id.size());
  endtask

  logic [31:0] d3[4];

  initial begin
    d3[0] = 32'h1111_0000; d3[1] = 32'h2222_0001; d3[2] = 32'h3333_0002; d3[3] = 32'h4444_0003;
    cyc = 0;
    model_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wren", bus.memctrl0_wren, 0);
    chk("rst_rden", bus.memctrl0_rden, 0);
    chk("rst_outstanding", o_outstanding, 0);
    chk("rst_err", o_err_oval, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // both writers held for 20 cycles: requester 1 wins only after 8 straight denials
    bus.a0_wren = 1; bus.a0_wadd = 32'hA000; bus.a0_idat = 32'h0;
    bus.a1_wren = 1; bus.a1_wadd = 32'hB000; bus.a1_idat = 32'hB;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t1_a1_grant", bus.a1_wrdy, (i == 8 || i == 17));
      step();
      bus.a0_idat = i + 1;
    end
    bus.a0_wren = 0; bus.a1_wren = 0;
    step();

    // single read from requester 1
    bus.a1_rden = 1; bus.a1_radd = 32'h40;
    step();
    bus.a1_rden = 0;
    step(); step(); step();
    bus.memctrl0_oval = 1; bus.memctrl0_odat = 32'hDEADBEEF;
    step();
    bus.memctrl0_oval = 0;
    chk("t2_a1_oval", bus.a1_oval, 1);
    chk("t2_a1_odat", bus.a1_odat, 32'hDEADBEEF);
    chk("t2_a0_oval", bus.a0_oval, 0);
    step();

    // interleaved reads return to the issuing requester in order
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin bus.a0_rden = 1; bus.a0_radd = 32'h100 + k; end
      else            begin bus.a1_rden = 1; bus.a1_radd = 32'h100 + k; end
      step();
      bus.a0_rden = 0; bus.a1_rden = 0;
    end
    step();
    for (int k = 0; k < 4; k++) begin
      bus.memctrl0_oval = 1; bus.memctrl0_odat = d3[k];
      step();
      chk("t3_oval", {bus.a1_oval, bus.a0_oval}, (k % 2) ? 2'b10 : 2'b01);
      chk("t3_odat", (k % 2) ? bus.a1_odat : bus.a0_odat, d3[k]);
    end
    bus.memctrl0_oval = 0;
    step();

    // fill the tag FIFO, then pop while full and pop+push at count 3
    bus.a0_rden = 1;
    for (int i = 0; i < 4; i++) begin bus.a0_radd = 32'h200 + i; step(); end
    bus.a0_radd = 32'h2FF;
    step();
    #1;
    chk("t4_count_full", o_outstanding, 4);
    chk("t4_a0_rrdy_full", bus.a0_rrdy, 0);
    chk("t4_a1_rrdy_full", bus.a1_rrdy, 0);
    bus.memctrl0_oval = 1; bus.memctrl0_odat = $urandom;
    step();
    #1;
    chk("t4_rrdy_back", bus.a0_rrdy, 1);
    chk("t4_count_3", o_outstanding, 3);
    bus.memctrl0_odat = $urandom;
    step();
    chk("t4_push_pop", o_outstanding, 3);
    bus.a0_rden = 0;
    for (int i = 0; i < 3; i++) begin bus.memctrl0_odat = $urandom; step(); end
    bus.memctrl0_oval = 0;
    step();

    // randomized traffic honouring hold-until-granted
    for (int n = 0; n < 600; n++) begin
      if (!bus.a0_wren || g_w0) begin
        bus.a0_wren = ($urandom_range(3) != 0); bus.a0_wadd = $urandom; bus.a0_idat = $urandom;
      end
      if (!bus.a1_wren || g_w1) begin
        bus.a1_wren = ($urandom_range(3) != 0); bus.a1_wadd = $urandom; bus.a1_idat = $urandom;
      end
      if (!bus.a0_rden || g_r0) begin
        bus.a0_rden = ($urandom_range(2) != 0); bus.a0_radd = $urandom;
      end
      if (!bus.a1_rden || g_r1) begin
        bus.a1_rden = ($urandom_range(2) != 0); bus.a1_radd = $urandom;
      end
      bus.memctrl0_oval = (q_id.size() != 0) && (cyc - q_cyc[0] >= 2) && ($urandom_range(2) != 0);
      bus.memctrl0_odat = $urandom;
      step();
    end
    bus.a0_wren = 0; bus.a1_wren = 0; bus.a0_rden = 0; bus.a1_rden = 0;
    for (int n = 0; n < 20 && q_id.size() != 0; n++) begin
      bus.memctrl0_oval = (cyc - q_cyc[0] >= 2);
      bus.memctrl0_odat = $urandom;
      step();
    end
    bus.memctrl0_oval = 0;
    chk("drain_empty", o_outstanding, 0);

    // stray return with nothing outstanding
    bus.memctrl0_oval = 1; bus.memctrl0_odat = 32'hBAD0BAD0;
    step();
    bus.memctrl0_oval = 0;
    chk("t5_err", o_err_oval, 1);
    chk("t5_no_oval", {bus.a1_oval, bus.a0_oval}, 2'b00);
    repeat (3) step();
    chk("t5_sticky", o_err_oval, 1);

    // async reset with two reads in flight
    bus.a0_rden = 1; bus.a0_radd = 32'h300; step();
    bus.a0_rden = 0; bus.a1_rden = 1; bus.a1_radd = 32'h304; step();
    bus.a1_rden = 0; step();
    chk("t6_pre_count", o_outstanding, 2);
    bus.a0_rden = 1; bus.a1_wren = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_a0_rrdy", bus.a0_rrdy, 0);
    chk("t6_a1_wrdy", bus.a1_wrdy, 0);
    chk("t6_count", o_outstanding, 0);
    chk("t6_err", o_err_oval, 0);
    chk("t6_wadd", bus.memctrl0_wadd, 0);
    chk("t6_a1_odat", bus.a1_odat, 0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.memctrl0_oval = 1; bus.memctrl0_odat = 32'h5555AAAA;
    step();
    bus.memctrl0_oval = 0;
    chk("t6_stray_err", o_err_oval, 1);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
